mcu_link_select: RTL and testbench

MCU_LINK_SELECT -- requirements
Module: mcu_link_select

---
 rtl/mcu_link_select.sv | 144 ++++++++++++++
 tb/tb_mcu_link_select.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_link_select.sv
// Selects between the on-board BL616 and an external M0S Dock as the SPI master.
// A dock is accepted after a sustained ext_csn low, then switched in on an idle bus.
module mcu_link_select #(
    parameter int SYNC_STAGES   = 2,
    parameter int DETECT_CYCLES = 16,
    parameter int IDLE_CYCLES   = 8
) (
    input  logic       clk32,
    input  logic       rst_n,
    input  logic       int_sclk,
    input  logic       int_csn,
    input  logic       int_mosi,
    input  logic       ext_sclk,
    input  logic       ext_csn,
    input  logic       ext_mosi,
    output logic       mcu_sclk,
    output logic       mcu_csn,
    output logic       mcu_mosi,
    input  logic       core_miso,
    input  logic       core_intn,
    output logic       int_miso,
    output logic       ext_miso,
    output logic       int_intn,
    output logic       ext_intn,
    output logic       ext_active,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_INT    = 2'b00,
        ST_DETECT = 2'b01,
        ST_ARMED  = 2'b10,
        ST_EXT    = 2'b11
    } state_e;

    localparam logic [7:0] DET_TH  = 8'(DETECT_CYCLES);
    localparam logic [7:0] IDLE_TH = 8'(IDLE_CYCLES);
    // Bit order {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk}; csn idles high
    localparam logic [5:0] SYNC_RST = 6'b010_010;

    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] sync_d [SYNC_STAGES];
    logic [5:0] sync_s;

    state_e     state_q, state_d;
    logic [7:0] det_q, det_d;
    logic [7:0] idle_q, idle_d;
    logic [7:0] det_inc, idle_inc;
    logic [2:0] mcu_q, mcu_d;
    logic       ext_active_q, ext_active_d;

    always_comb begin
        sync_d[0] = {ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign det_inc  = (det_q == 8'hFF) ? det_q : det_q + 8'd1;
    assign idle_inc = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

    always_comb begin
        state_d = state_q;
        det_d   = det_q;
        idle_d  = idle_q;
        unique case (state_q)
            ST_INT: begin
                if (!sync_s[4]) begin
                    state_d = ST_DETECT;
                    det_d   = 8'd1;
                end
            end
            ST_DETECT: begin
                // Only the ext_csn sample decides here; int_csn is ignored
                if (sync_s[4]) begin
                    state_d = ST_INT;
                    det_d   = 8'd0;
                end else if (det_inc >= DET_TH) begin
                    state_d = ST_ARMED;
                    det_d   = 8'd0;
                    idle_d  = 8'd0;
                end else begin
                    det_d = det_inc;
                end
            end
            ST_ARMED: begin
                if (sync_s[1] && sync_s[4]) begin
                    if (idle_inc >= IDLE_TH) begin
                        state_d = ST_EXT;
                        idle_d  = 8'd0;
                    end else begin
                        idle_d = idle_inc;
                    end
                end else begin
                    idle_d = 8'd0;
                end
            end
            ST_EXT: begin
                state_d = ST_EXT;
            end
        endcase
    end

    // Mux keys on the next state so the select flips on the edge EXT is entered
    always_comb begin
        mcu_d        = (state_d == ST_EXT) ? sync_s[5:3] : sync_s[2:0];
        ext_active_d = (state_d == ST_EXT);
    end

    always_ff @(posedge clk32 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            state_q      <= ST_INT;
            det_q        <= 8'd0;
            idle_q       <= 8'd0;
            mcu_q        <= 3'b010;
            ext_active_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            state_q      <= state_d;
            det_q        <= det_d;
            idle_q       <= idle_d;
            mcu_q        <= mcu_d;
            ext_active_q <= ext_active_d;
        end
    end

    assign mcu_sclk   = mcu_q[0];
    assign mcu_csn    = mcu_q[1];
    assign mcu_mosi   = mcu_q[2];
    assign ext_active = ext_active_q;
    assign state      = state_q;

    assign int_miso = core_miso;
    assign ext_miso = core_miso;
    assign int_intn = core_intn;
    assign ext_intn = core_intn;

endmodule

// File: tb/tb_mcu_link_select.sv
// Randomized bench for mcu_link_select against a delay-line plus
// sample-counting reference model of the dock acceptance rules.
module tb_mcu_link_select;

    localparam int S  = 2;
    localparam int DC = 16;
    localparam int IC = 8;

    logic       clk32 = 1'b0;
    logic       rst_n = 1'b1;
    logic       int_sclk = 1'b0, int_csn = 1'b1, int_mosi = 1'b0;
    logic       ext_sclk = 1'b0, ext_csn = 1'b1, ext_mosi = 1'b0;
    logic       mcu_sclk, mcu_csn, mcu_mosi;
    logic       core_miso = 1'b0, core_intn = 1'b1;
    logic       int_miso, ext_miso, int_intn, ext_intn;
    logic       ext_active;
    logic [1:0] state;

    int vectors = 0;
    int miscompares = 0;

    mcu_link_select #(
        .SYNC_STAGES  (S),
        .DETECT_CYCLES(DC),
        .IDLE_CYCLES  (IC)
    ) dut (
        .clk32     (clk32),
        .rst_n     (rst_n),
        .int_sclk  (int_sclk),
        .int_csn   (int_csn),
        .int_mosi  (int_mosi),
        .ext_sclk  (ext_sclk),
        .ext_csn   (ext_csn),
        .ext_mosi  (ext_mosi),
        .mcu_sclk  (mcu_sclk),
        .mcu_csn   (mcu_csn),
        .mcu_mosi  (mcu_mosi),
        .core_miso (core_miso),
        .core_intn (core_intn),
        .int_miso  (int_miso),
        .ext_miso  (ext_miso),
        .int_intn  (int_intn),
        .ext_intn  (ext_intn),
        .ext_active(ext_active),
        .state     (state)
    );

    always #15 clk32 = ~clk32;

    // Reference model: mode 0=INT 1=DETECT 2=ARMED 3=EXT
    int         m_mode = 0;
    int         m_run  = 0;
    int         m_idle = 0;
    logic [5:0] hist[$];
    logic       m_sclk = 1'b0, m_csn = 1'b1, m_mosi = 1'b0;

    function automatic void model_reset();
        hist.delete();
        m_mode = 0;
        m_run  = 0;
        m_idle = 0;
        m_sclk = 1'b0;
        m_csn  = 1'b1;
        m_mosi = 1'b0;
    endfunction

    function automatic void model_edge();
        logic [5:0] s;
        hist.push_back({ext_mosi, ext_csn, ext_sclk, int_mosi, int_csn, int_sclk});
        if (hist.size() > S + 1) void'(hist.pop_front());
        s = (hist.size() == S + 1) ? hist[0] : 6'b010_010;
        if (m_mode == 0) begin
            if (!s[4]) begin m_mode = 1; m_run = 1; end
        end else if (m_mode == 1) begin
            if (s[4]) begin
                m_mode = 0; m_run = 0;
            end else begin
                m_run = m_run + 1;
                if (m_run >= DC) begin m_mode = 2; m_idle = 0; end
            end
        end else if (m_mode == 2) begin
            if (s[1] && s[4]) begin
                m_idle = m_idle + 1;
                if (m_idle >= IC) m_mode = 3;
            end else begin
                m_idle = 0;
            end
        end
        if (m_mode == 3) {m_mosi, m_csn, m_sclk} = s[5:3];
        else             {m_mosi, m_csn, m_sclk} = s[2:0];
    endfunction

    task automatic cycle();
        @(posedge clk32);
        if (!rst_n) model_reset();
        else        model_edge();
        @(negedge clk32);
        vectors += 5;
        if (state !== 2'(m_mode)) begin
            miscompares++;
            $display("FAIL state: got %0d want %0d @%0t", state, m_mode, $time);
        end
        if (ext_active !== (m_mode == 3)) begin
            miscompares++;
            $display("FAIL ext_active: got %b want %b @%0t", ext_active, m_mode == 3, $time);
        end
        if (mcu_sclk !== m_sclk) begin
            miscompares++;
            $display("FAIL mcu_sclk: got %b want %b @%0t", mcu_sclk, m_sclk, $time);
        end
        if (mcu_csn !== m_csn) begin
            miscompares++;
            $display("FAIL mcu_csn: got %b want %b @%0t", mcu_csn, m_csn, $time);
        end
        if (mcu_mosi !== m_mosi) begin
            miscompares++;
            $display("FAIL mcu_mosi: got %b want %b @%0t", mcu_mosi, m_mosi, $time);
        end
        core_miso = 1'($urandom);
        core_intn = 1'($urandom);
        #1;
        vectors += 4;
        if (int_miso !== core_miso || ext_miso !== core_miso) begin
            miscompares++;
            $display("FAIL miso_fanout: got %b/%b want %b", int_miso, ext_miso, core_miso);
        end
        if (int_intn !== core_intn || ext_intn !== core_intn) begin
            miscompares++;
            $display("FAIL intn_fanout: got %b/%b want %b", int_intn, ext_intn, core_intn);
        end
    endtask

    task automatic rand_data();
        int_sclk = 1'($urandom);
        int_mosi = 1'($urandom);
        ext_sclk = 1'($urandom);
        ext_mosi = 1'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk32);
        rst_n = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        rand_data();
        #1;
        vectors++;
        if (state !== 2'b00 || ext_active !== 1'b0 || mcu_csn !== 1'b1 ||
            mcu_sclk !== 1'b0 || mcu_mosi !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got st=%b act=%b csn=%b sclk=%b mosi=%b",
                     state, ext_active, mcu_csn, mcu_sclk, mcu_mosi);
        end
        repeat (3) cycle();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_int_path();
        ext_csn  = 1'b1;
        int_csn  = 1'b0;
        int_mosi = 1'b0;
        repeat (5) begin
            int_sclk = ~int_sclk;
            cycle();
        end
        int_mosi = 1'b1;
        for (int i = 0; i < S; i++) begin
            cycle();
            vectors++;
            if (mcu_mosi !== 1'b0) begin
                miscompares++;
                $display("FAIL mosi_early: got %b want 0 at cycle %0d", mcu_mosi, i);
            end
        end
        cycle();
        vectors++;
        if (mcu_mosi !== 1'b1) begin
            miscompares++;
            $display("FAIL mosi_latency: got %b want 1", mcu_mosi);
        end
        repeat (25) begin
            int_sclk = 1'($urandom);
            int_mosi = 1'($urandom);
            int_csn  = 1'($urandom);
            ext_sclk = 1'($urandom);
            cycle();
        end
    endtask

    task automatic test_glitch();
        bit saw_detect = 0;
        int_csn = 1'b1;
        ext_csn = 1'b0;
        repeat (10) begin
            rand_data();
            cycle();
            if (state == 2'b01) saw_detect = 1;
        end
        ext_csn = 1'b1;
        repeat (S + 4) begin
            rand_data();
            cycle();
        end
        vectors++;
        if (!saw_detect || state !== 2'b00) begin
            miscompares++;
            $display("FAIL glitch_reject: got saw_detect=%0d state=%b want 1/00",
                     saw_detect, state);
        end
    endtask

    task automatic test_switch();
        ext_csn = 1'b0;
        int_csn = 1'b1;
        repeat (20) begin
            rand_data();
            cycle();
        end
        ext_csn = 1'b1;
        repeat (S + IC + 4) begin
            rand_data();
            cycle();
        end
        repeat (10) begin
            ext_sclk = 1'($urandom);
            int_sclk = ~ext_sclk;
            ext_csn  = 1'($urandom);
            int_csn  = 1'($urandom);
            cycle();
        end
        vectors++;
        if (state !== 2'b11 || ext_active !== 1'b1) begin
            miscompares++;
            $display("FAIL switch_ext: got state=%b act=%b want 11/1", state, ext_active);
        end
    endtask

    task automatic test_idle_break();
        logic prev_csn;
        bit   switched = 0;
        do_reset();
        int_csn = 1'b1;
        ext_csn = 1'b0;
        repeat (20) begin
            rand_data();
            cycle();
        end
        ext_csn = 1'b1;
        repeat (S + 4) begin
            rand_data();
            cycle();
        end
        int_csn = 1'b0;
        rand_data();
        cycle();
        int_csn = 1'b1;
        prev_csn = mcu_csn;
        for (int i = 0; i < S + IC + 6; i++) begin
            rand_data();
            cycle();
            if (!switched && ext_active) begin
                switched = 1;
                vectors++;
                if (mcu_csn !== 1'b1 || prev_csn !== 1'b1) begin
                    miscompares++;
                    $display("FAIL splice: got csn before=%b after=%b want 1/1",
                             prev_csn, mcu_csn);
                end
            end
            prev_csn = mcu_csn;
        end
        vectors++;
        if (!switched) begin
            miscompares++;
            $display("FAIL idle_restart: got no switch want EXT entered");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk32);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (state !== 2'b00 || ext_active !== 1'b0 || mcu_csn !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got st=%b act=%b csn=%b want 00/0/1",
                     state, ext_active, mcu_csn);
        end
        #2 rst_n = 1'b1;
        model_reset();
        ext_csn = 1'b1;
        int_csn = 1'b0;
        repeat (12) begin
            int_sclk = ~int_sclk;
            ext_sclk = ~int_sclk;
            cycle();
        end
        vectors++;
        if (mcu_sclk !== int_sclk) begin
            miscompares++;
            $display("FAIL post_reset_int: got %b want %b", mcu_sclk, int_sclk);
        end
    endtask

    task automatic test_fanout();
        for (int i = 0; i < 4; i++) begin
            core_miso = i[0];
            core_intn = i[1];
            #1;
            vectors++;
            if ({int_miso, ext_miso, int_intn, ext_intn} !==
                {core_miso, core_miso, core_intn, core_intn}) begin
                miscompares++;
                $display("FAIL fanout_combo: got %b%b%b%b for miso=%b intn=%b",
                         int_miso, ext_miso, int_intn, ext_intn, core_miso, core_intn);
            end
        end
    endtask

    initial begin
        test_reset();
        test_int_path();
        test_glitch();
        test_switch();
        test_fanout();
        test_async_reset();
        test_idle_break();
        test_fanout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
